// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select pins of a 4:1 mux (e1..e4 -> x).
// One grant at a time, released by done, a dropped request, or a hold timeout.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;

  logic       win_vld;
  logic [1:0] win_idx;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_hold;

  // First set request scanning from ptr upward, wrapping mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    {win_vld, win_idx} = pick(req, ptr);
    rel_done = done;
    rel_drop = ~req[sel];
    rel_hold = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'b00;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 2'b00;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt   <= 4'b0001 << win_idx;
            sel   <= win_idx;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (rel_done || rel_drop || rel_hold) begin
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            ptr     <= sel + 2'd1;
            state   <= IDLE;
            // Only a pure timeout is flagged; done or a dropped request wins.
            timeout <= rel_hold && !rel_done && !rel_drop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a behavioural 4:1 mux on its selects.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       s1, s0, busy, timeout;

  int errors = 0;
  int checks = 0;

  logic [7:0] e [4];
  logic [7:0] x;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .s1(s1), .s0(s0), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign x = e[{s1, s0}];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] sl,
                         input logic b, input logic t);
    chk({tag, ".gnt"}, {4'b0, gnt}, {4'b0, g});
    chk({tag, ".sel"}, {6'b0, s1, s0}, {6'b0, sl});
    chk({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
    chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      int gi;
      gi = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) gi = i;
      chk("inv.onehot", {7'b0, $onehot0(gnt)}, 8'd1);
      chk("inv.busy", {7'b0, busy}, {7'b0, gnt != 4'b0000});
      if (busy) chk("inv.x", x, e[gi]);
    end
  end

  initial begin
    logic [3:0] order [5];
    logic [1:0] sels  [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sels  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b1; req = 4'b0000; done = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1 chk_out("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // done in IDLE is ignored
    done = 1'b1; tick(); done = 1'b0;
    chk_out("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request on e3, released by done
    req = 4'b0100; tick();
    chk_out("e3_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    chk("e3_x", x, 8'h33);
    done = 1'b1; req = 4'b0000; tick(); done = 1'b0;
    chk_out("e3_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Full round robin from ptr=0
    #2 rst_n = 1'b0; #1 rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), order[i], sels[i], 1'b1, 1'b0);
      done = 1'b1;
      if (i == 4) req = 4'b0000;
      tick(); done = 1'b0;
      chk_out($sformatf("rr%0d_rel", i), 4'b0000, sels[i], 1'b0, 1'b0);
    end

    // Hold timeout: 8 granted cycles, pulse, one idle cycle, re-grant
    req = 4'b0001; tick();
    chk_out("to_c0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 1; c < 8; c++) begin
      tick();
      chk_out($sformatf("to_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_out("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_out("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000; tick();
    chk_out("to_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Dropped request on ch1 moves ptr to 2; then 0011 resolves to ch0
    req = 4'b0010; tick();
    chk_out("drop_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000; tick();
    chk_out("drop_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    req = 4'b0011; tick();
    chk_out("drop_next", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1; req = 4'b0000; tick(); done = 1'b0;
    chk_out("drop_next_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

    // done coincident with timeout: release without pulse
    req = 4'b0100; tick();
    chk_out("dt_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int c = 1; c < 8; c++) tick();
    chk_out("dt_c7", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1; tick(); done = 1'b0; req = 4'b0000;
    chk_out("dt_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Reset mid-grant on ch3 with cnt=4
    req = 4'b1000; tick();
    chk_out("mr_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) tick();
    #2 rst_n = 1'b0;
    #1 chk_out("mr_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("mr_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    // Fresh reset leaves ptr at 0, so 1001 resolves to ch0
    #2 rst_n = 1'b0; #1 rst_n = 1'b1;
    req = 4'b1001; tick();
    chk_out("mr_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1; req = 4'b0000; tick(); done = 1'b0;
    chk_out("end_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
